// File: rtl/decode_issue_if.sv
// Instruction intake and store-drain handshakes between decode_issue and its neighbours.
// Valid/ready: a transfer happens at a rising edge where both are 1; valid never waits on ready.
interface decode_issue_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          inst_valid_in;
  logic          inst_ready_out;
  logic [31:0]   inst_in;
  logic          st_valid_out;
  logic          st_ready_in;
  logic [AW-1:0] st_addr_out;
  logic [DW-1:0] st_data_out;

  modport master (
    output inst_valid_in, inst_in, st_ready_in,
    input  inst_ready_out, st_valid_out, st_addr_out, st_data_out
  );

  modport slave (
    input  inst_valid_in, inst_in, st_ready_in,
    output inst_ready_out, st_valid_out, st_addr_out, st_data_out
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes instructions, reads the register file with forwarding from the
// single-cycle issue register, retires ALU results and carry, and drains STORE data.
module decode_issue #(
  parameter  int NREG = 16,
  parameter  int DW   = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_issue_if.slave bus,
  output logic [4:0]    opcode_out,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  input  logic [DW-1:0] result_alu_in,
  input  logic          carry_alu_in,
  output logic          carry_flag_out,
  output logic          illegal_out,
  input  logic [AW-1:0] dbg_addr_in,
  output logic [DW-1:0] dbg_data_out
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b11011;

  // Instruction fields
  logic [4:0]    dec_op;
  logic [AW-1:0] dec_rd;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic          unused_inst_bits;

  assign dec_op           = bus.inst_in[31:27];
  assign dec_rd           = bus.inst_in[26:23];
  assign dec_rs1          = bus.inst_in[22:19];
  assign dec_rs2          = bus.inst_in[18:15];
  assign unused_inst_bits = ^bus.inst_in[14:0];

  // State
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic          iss_valid_q, iss_valid_d;
  logic [4:0]    iss_op_q, iss_op_d;
  logic [DW-1:0] iss_a_q, iss_a_d;
  logic [DW-1:0] iss_b_q, iss_b_d;
  logic [AW-1:0] iss_rd_q, iss_rd_d;
  logic          iss_wen_q, iss_wen_d;
  logic          iss_store_q, iss_store_d;
  logic          st_valid_q, st_valid_d;
  logic [AW-1:0] st_addr_q, st_addr_d;
  logic [DW-1:0] st_data_q, st_data_d;
  logic          carry_q, carry_d;
  logic          illegal_q, illegal_d;

  logic          dec_legal;
  logic          accept;
  logic          iss_commit;
  logic          st_load;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;

  always_comb begin
    dec_legal = 1'b0;
    if (dec_op <= 5'b01011) begin
      dec_legal = 1'b1;
    end else begin
      case (dec_op)
        5'b11000, 5'b11010, 5'b11011, 5'b11100, 5'b11110: dec_legal = 1'b1;
        default:                                          dec_legal = 1'b0;
      endcase
    end
  end

  // A STORE in issue or a stalled store register blocks intake so a new STORE always finds room.
  assign bus.inst_ready_out = ~(st_valid_q & ~bus.st_ready_in) & ~(iss_valid_q & iss_store_q);
  assign accept             = bus.inst_valid_in & bus.inst_ready_out;
  assign iss_commit         = iss_valid_q & iss_wen_q;
  assign st_load            = iss_valid_q & iss_store_q;

  // Operand read; the op currently at the ALU has not committed yet, so its result is bypassed.
  always_comb begin
    opa = '0;
    opb = '0;
    if (dec_rs1 != '0) begin
      opa = (iss_commit && iss_rd_q == dec_rs1) ? result_alu_in : rf_q[dec_rs1];
    end
    if (dec_rs2 != '0) begin
      opb = (iss_commit && iss_rd_q == dec_rs2) ? result_alu_in : rf_q[dec_rs2];
    end
  end

  always_comb begin
    iss_valid_d = 1'b0;
    iss_op_d    = OP_NOP;
    iss_a_d     = '0;
    iss_b_d     = '0;
    iss_rd_d    = '0;
    iss_wen_d   = 1'b0;
    iss_store_d = 1'b0;
    illegal_d   = illegal_q;
    if (accept) begin
      iss_valid_d = 1'b1;
      if (dec_legal) begin
        iss_op_d    = dec_op;
        iss_a_d     = opa;
        iss_b_d     = opb;
        iss_rd_d    = dec_rd;
        iss_wen_d   = (dec_op != OP_NOP) && (dec_op != OP_STORE);
        iss_store_d = (dec_op == OP_STORE);
      end else begin
        illegal_d   = 1'b1;
      end
    end
  end

  always_comb begin
    rf_d    = rf_q;
    carry_d = carry_q;
    if (iss_commit) begin
      carry_d = carry_alu_in;
      if (iss_rd_q != '0) begin
        rf_d[iss_rd_q] = result_alu_in;
      end
    end
  end

  // A new load wins over a same-edge drain.
  always_comb begin
    st_valid_d = st_valid_q & ~bus.st_ready_in;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    if (st_load) begin
      st_valid_d = 1'b1;
      st_addr_d  = iss_rd_q;
      st_data_d  = result_alu_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      iss_valid_q <= 1'b0;
      iss_op_q    <= OP_NOP;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_rd_q    <= '0;
      iss_wen_q   <= 1'b0;
      iss_store_q <= 1'b0;
      st_valid_q  <= 1'b0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_rd_q    <= iss_rd_d;
      iss_wen_q   <= iss_wen_d;
      iss_store_q <= iss_store_d;
      st_valid_q  <= st_valid_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
      carry_q     <= carry_d;
      illegal_q   <= illegal_d;
    end
  end

  assign opcode_out      = iss_op_q;
  assign a_out           = iss_a_q;
  assign b_out           = iss_b_q;
  assign bus.st_valid_out = st_valid_q;
  assign bus.st_addr_out  = st_addr_q;
  assign bus.st_data_out  = st_data_q;
  assign carry_flag_out  = carry_q;
  assign illegal_out     = illegal_q;
  assign dbg_data_out    = (dbg_addr_in == '0) ? '0 : rf_q[dbg_addr_in];

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Front end of the execute path; it produces the opcode/operand bundle the ALU consumes and retires the result and carry the ALU returns.
- Accepts 32-bit instruction words over a valid/ready handshake, decodes them and reads a 16x32 register file.
- Forwards the in-flight result to the next instruction.
- Writes results back, keeps a carry flag, and emits STORE data through a valid/ready store port.

Parameters:
- NREG, 16, register-file depth (register index width = 4; r0 hardwired to zero)
- DW, 32, datapath width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_valid_in  in  1  instruction word valid
- inst_ready_out  out  1  block can accept an instruction this cycle
- inst_in  in  32  instruction: [31:27] opcode, [26:23] rd, [22:19] rs1, [18:15] rs2, [14:0] ignored
- opcode_out  out  5  opcode to ALU (00000 when idle)
- a_out  out  32  operand A to ALU
- b_out  out  32  operand B to ALU
- result_alu_in  in  32  ALU result, combinational from opcode_out/a_out/b_out
- carry_alu_in  in  1  ALU carry out
- st_valid_out  out  1  store data valid
- st_ready_in  in  1  store consumer accepts
- st_addr_out  out  4  store address (rd field of the STORE)
- st_data_out  out  32  store data (ALU result of the STORE)
- carry_flag_out  out  1  carry of the last register-writing op
- illegal_out  out  1  sticky: an undefined opcode was accepted
- dbg_addr_in  in  4  debug register-file read index
- dbg_data_out  out  32  committed register value, combinational; r0 reads 0

Behaviour:
- Reset (async, rst_n=0):
  - All registers, carry_flag_out, illegal_out, st_valid_out and the issue-valid bit clear to 0.
  - opcode_out, a_out, b_out, st_addr_out and st_data_out are 0.
  - inst_ready_out=1 once reset releases.
- Legal opcodes: 00000-00111, 01000-01011, 11000, 11010, 11011, 11100, 11110.
  - Register-writing (wen=1): every legal opcode except 00000 (NOP) and 11011 (STORE).
- Accept: inst_valid_in & inst_ready_out at a rising edge loads the issue register, which drives the ALU for exactly one cycle.
  - Loaded fields: opcode, a, b, rd, wen, store.
  - The cycle after, with no new accept, the issue-valid bit clears and opcode_out=00000, a_out=b_out=0.
- Illegal opcode: loaded as NOP (opcode_out=00000, wen=0, store=0); illegal_out set and held until reset.
- Operand read at accept, for each of rs1→a and rs2→b:
  - index 0 → 0;
  - else if the issue register is valid, has wen=1 and its rd equals the index → result_alu_in (forwarded);
  - else the register-file value.
- Writeback: at the end of each issue cycle with valid & wen & rd≠0, reg[rd] ← result_alu_in and carry_flag_out ← carry_alu_in.
  - With wen and rd=0, the carry flag still updates but no register is written.
- Latency: accept at edge N; the ALU sees the op during cycle N→N+1; the result is committed at edge N+1.
  - Dependent back-to-back instructions run at full rate with no stall.
- STORE:
  - At the end of its issue cycle the store register loads st_addr_out←rd, st_data_out←result_alu_in and st_valid_out←1.
  - st_valid_out falls at an edge where st_ready_in=1, unless a new store loads at that same edge (load wins; st_valid_out stays 1).
  - st_addr_out/st_data_out hold stable while st_valid_out & ~st_ready_in.
- inst_ready_out = ~(st_valid_out & ~st_ready_in) & ~(issue_valid & issue_store).
  - This guarantees the store register is free or draining when a STORE issues. Consecutive stores are therefore spaced at least 2 cycles apart.
- Reset asserted mid-operation discards the issue register and any pending store; no writeback occurs.
- Simultaneous debug read and write to the same register: dbg_data_out shows the old value until the edge.

Test Plan:
- Reset → inst_ready_out=1, st_valid_out=0, carry_flag_out=0, illegal_out=0, dbg_data_out=0 for every dbg_addr_in.
- INC r1←r0 (opcode 00001, rd=1, rs1=0), with an ALU model on result_alu_in/carry_alu_in → next cycle opcode_out=00001, a_out=0; the cycle after, opcode_out=00000 and dbg r1=1.
- INC r1←r0, then ADD r2←r1,r1 on the following cycle → second issue shows a_out=b_out=1 (forwarded); r2=2.
- DEC r3←r0 (00110) → a_out=0, result FFFFFFFF, carry 1; r3=FFFFFFFF, carry_flag_out=1. Then OR r4←r3,r0 → carry_flag_out=0.
- With st_ready_in=0: STORE rd=5 rs1=r1 (=1) → st_valid_out=1, st_addr_out=5, st_data_out=1, inst_ready_out=0, values held for 3 cycles. Pulse st_ready_in=1 → st_valid_out=0 and inst_ready_out=1 the next cycle.
- Opcode 01100 rd=6 → opcode_out=00000, r6 unchanged, illegal_out=1 and stays 1 across later legal instructions until rst_n=0.
